// File: rtl/fetch_pkg.sv
// fetch_pkg: shared config for fetch and decode (instruction width, opcodes, fetch states)
package fetch_pkg;
    localparam int FETCH_I_SIZE = 32;
    localparam logic [6:0] OPC_JMP = 7'h0e;
    localparam logic [6:0] OPC_JAL = 7'h0f;
    localparam logic [6:0] OPC_IRT = 7'h1e;
    typedef enum logic {REQ = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/fetch_predict.sv
// fetch_predict: static jump prediction, unconditional JMP and JAL taken, everything else falls through
module fetch_predict import fetch_pkg::*; (
    input  logic [6:0]  opcode,
    input  logic [3:0]  cond,
    input  logic [15:0] target,
    input  logic [15:0] pc,
    output logic        pred,
    output logic [15:0] next_pc
);
    // IRT falls through here; execute redirects it with a flush
    always_comb begin
        pred = (opcode == OPC_JMP && cond == 4'd0) || opcode == OPC_JAL;
        next_pc = pred ? target : pc + 16'd1;
    end
endmodule

// File: rtl/fetch.sv
// fetch: instruction fetch stage, one word per memory request, handed to decode via submit/ready
module fetch import fetch_pkg::*; #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          I_SIZE   = FETCH_I_SIZE
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_mem_req,
    output logic [15:0]       o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [I_SIZE-1:0] i_mem_data,
    input  logic              i_next_ready,
    output logic              o_submit,
    output logic [15:0]       o_instr_l,
    output logic [I_SIZE-17:0] o_imm_pass,
    output logic              o_jmp_pred_pass,
    input  logic              i_flush,
    input  logic [15:0]       i_flush_pc
);
    state_t state, state_n;
    logic [15:0] pc;
    logic discard;
    logic [I_SIZE-1:0] word_q;
    logic take, fire, pend, p_pred;
    logic [15:0] p_next;
    fetch_predict u_predict (
        .opcode  (word_q[6:0]),
        .cond    (word_q[10:7]),
        .target  (word_q[31:16]),
        .pc      (pc),
        .pred    (p_pred),
        .next_pc (p_next)
    );
    always_comb begin
        pend = o_mem_req && !i_mem_ack;
        take = !i_flush && state == REQ && o_mem_req && i_mem_ack && !discard;
        fire = !i_flush && state == HOLD && i_next_ready;
        state_n = i_flush ? REQ : take ? HOLD : fire ? REQ : state;
    end
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= REQ;
        else          state <= state_n;
    // o_mem_addr diverges from pc only while a pre-flush request is being drained
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc <= RESET_PC;
            o_mem_addr <= RESET_PC;
            o_mem_req <= 1'b0;
            discard <= 1'b0;
            word_q <= '0;
            o_submit <= 1'b0;
            o_instr_l <= '0;
            o_imm_pass <= '0;
            o_jmp_pred_pass <= 1'b0;
        end else begin
            o_submit <= fire;
            if (i_flush) begin
                pc <= i_flush_pc;
                o_mem_req <= 1'b1;
                discard <= pend;
                if (!pend) o_mem_addr <= i_flush_pc;
            end else if (state == REQ) begin
                o_mem_req <= !take;
                if (o_mem_req && i_mem_ack && discard) begin
                    discard <= 1'b0;
                    o_mem_addr <= pc;
                end
                if (take) word_q <= i_mem_data;
            end else if (i_next_ready) begin
                o_instr_l <= word_q[15:0];
                o_imm_pass <= word_q[I_SIZE-1:16];
                o_jmp_pred_pass <= p_pred;
                pc <= p_next;
                o_mem_addr <= p_next;
                o_mem_req <= 1'b1;
            end
        end
    end
endmodule
